store_unit: RTL and testbench

Write-path counterpart of the MEM-stage load logic: accepts store requests from the pipeline, checks alignment, and converts size and byte offset into a word-aligned address, lane-shifted data and byte strobes. Accepted stores are queued in a small FIFO store buffer and drained to data memory over a valid/ready handshake. The unit also reports empty status for fences, and flags loads that hit a word still waiting in the buffer.

---
 rtl/dtcore32_pkg.sv | 17 +
 rtl/store_fifo.sv | 76 +++++++
 rtl/store_unit.sv | 128 ++++++++++++
 tb/tb_store_unit.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtcore32_pkg.sv
// dtcore32_pkg
// Shared definitions for the dtcore32 memory stage.
//   SIZE_B / SIZE_H / SIZE_W : bit positions inside the one-hot store size field
//   store_entry_t            : one store-buffer entry (word address, lane data, strobes)
package dtcore32_pkg;

   localparam int SIZE_B = 0;
   localparam int SIZE_H = 1;
   localparam int SIZE_W = 2;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
   } store_entry_t;

endpackage

// File: rtl/store_fifo.sv
// store_fifo
// Generic synchronous FIFO used as the store buffer.
//   clk_i, rst_i    : clock, synchronous active-high reset (clears pointers and storage)
//   push_i          : write push_data_i at the tail (ignored while full)
//   pop_i           : drop the head entry (ignored while empty)
//   head_o          : registered head entry
//   full_o, empty_o : occupancy status
//   entry_valid_o   : per-slot occupancy
//   entry_key_o     : per-slot key field (KEY_W bits starting at KEY_LSB of T)
import dtcore32_pkg::*;

module store_fifo #(
   parameter int  DEPTH   = 2,
   parameter type T       = store_entry_t,
   parameter int  KEY_LSB = 0,
   parameter int  KEY_W   = 1
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            push_i,
   input  T                                push_data_i,
   input  logic                            pop_i,
   output T                                head_o,
   output logic                            full_o,
   output logic                            empty_o,
   output logic [DEPTH-1:0]                entry_valid_o,
   output logic [DEPTH-1:0][KEY_W-1:0]     entry_key_o
);

   localparam int PW = $clog2(DEPTH);

   T               mem [DEPTH];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [PW:0]    count;
   logic           push_ok;
   logic           pop_ok;

   assign full_o  = (count == (PW+1)'(DEPTH));
   assign empty_o = (count == '0);
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;
   assign head_o  = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= push_data_i;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // A slot is occupied when its distance from the head is below the count.
   for (genvar g = 0; g < DEPTH; g++) begin : g_slot
      assign entry_valid_o[g] = ({1'b0, PW'(g) - rd_ptr} < count);
      assign entry_key_o[g]   = mem[g][KEY_LSB +: KEY_W];
   end

endmodule

// File: rtl/store_unit.sv
// store_unit
// Store path of the MEM stage: alignment check, lane formatting, store buffer
// drain to data memory, fence-empty status and load-after-store hazard detect.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   st_valid_i/st_ready_o   : store request handshake from the pipeline
//   st_addr_i, st_wdata_i   : byte address and unshifted store data
//   store_size_onehot       : [0] byte, [1] half, [2] word (lowest index wins)
//   misaligned_store_o      : combinational trap flag, store is dropped
//   mem_w*                  : buffer head towards data memory (valid/ready)
//   ld_valid_i, ld_addr_i   : load in MEM stage
//   ld_hazard_o             : load word matches a buffered store
//   sb_empty_o              : buffer empty
import dtcore32_pkg::*;

module store_unit #(
   parameter int DEPTH = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        st_valid_i,
   output logic        st_ready_o,
   input  logic [31:0] st_addr_i,
   input  logic [31:0] st_wdata_i,
   input  logic [2:0]  store_size_onehot,
   output logic        misaligned_store_o,
   output logic        mem_wvalid_o,
   input  logic        mem_wready_i,
   output logic [31:0] mem_waddr_o,
   output logic [31:0] mem_wdata_o,
   output logic [3:0]  mem_wstrb_o,
   input  logic        ld_valid_i,
   input  logic [31:0] ld_addr_i,
   output logic        ld_hazard_o,
   output logic        sb_empty_o
);

   localparam int KEY_W = 30;

   logic [1:0]                  off;
   logic                        size_valid;
   logic                        misaligned;
   logic [3:0]                  fmt_strb;
   logic [31:0]                 fmt_data;
   store_entry_t                push_entry;
   store_entry_t                head;
   logic                        push;
   logic                        pop;
   logic                        full;
   logic                        empty;
   logic                        hit;
   logic [DEPTH-1:0]            entry_valid;
   logic [DEPTH-1:0][KEY_W-1:0] entry_key;
   logic                        unused_ld_off;

   assign off        = st_addr_i[1:0];
   assign size_valid = |store_size_onehot;

   // Lowest set size bit wins; shifting zero-extended data leaves unstrobed lanes at 0.
   always_comb begin
      misaligned = 1'b0;
      fmt_strb   = 4'h0;
      fmt_data   = 32'h0;
      if (store_size_onehot[SIZE_B]) begin
         fmt_strb = 4'h1 << off;
         fmt_data = {24'h0, st_wdata_i[7:0]} << {off, 3'b000};
      end else if (store_size_onehot[SIZE_H]) begin
         misaligned = off[0];
         fmt_strb   = 4'h3 << {off[1], 1'b0};
         fmt_data   = {16'h0, st_wdata_i[15:0]} << {off[1], 4'b0000};
      end else if (store_size_onehot[SIZE_W]) begin
         misaligned = |off;
         fmt_strb   = 4'hf;
         fmt_data   = st_wdata_i;
      end
   end

   always_comb begin
      push_entry      = '0;
      push_entry.addr = {st_addr_i[31:2], 2'b00};
      push_entry.data = fmt_data;
      push_entry.strb = fmt_strb;
   end

   assign misaligned_store_o = st_valid_i & size_valid & misaligned;
   assign st_ready_o         = ~full;
   assign push               = st_valid_i & st_ready_o & size_valid & ~misaligned;
   assign pop                = mem_wvalid_o & mem_wready_i;

   store_fifo #(
      .DEPTH   (DEPTH),
      .T       (store_entry_t),
      .KEY_LSB ($bits(store_entry_t) - KEY_W),
      .KEY_W   (KEY_W)
   ) u_fifo (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .push_i        (push),
      .push_data_i   (push_entry),
      .pop_i         (pop),
      .head_o        (head),
      .full_o        (full),
      .empty_o       (empty),
      .entry_valid_o (entry_valid),
      .entry_key_o   (entry_key)
   );

   assign mem_wvalid_o = ~empty;
   assign sb_empty_o   = empty;
   assign mem_waddr_o  = head.addr;
   assign mem_wdata_o  = head.data;
   assign mem_wstrb_o  = head.strb;

   // Hazard looks only at stored entries, so a store pushed this cycle never matches.
   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (entry_valid[i] && (entry_key[i] == ld_addr_i[31:2])) begin
            hit = 1'b1;
         end
      end
   end

   assign ld_hazard_o = ld_valid_i & hit;

   // Byte offset of a load is irrelevant to a word-granular hazard.
   assign unused_ld_off = ^ld_addr_i[1:0];

endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit
// Self-checking bench for store_unit: directed scenarios followed by random
// traffic, compared against a queue-based model of the store buffer.
module tb_store_unit;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        st_valid;
   logic        st_ready;
   logic [31:0] st_addr;
   logic [31:0] st_wdata;
   logic [2:0]  st_size;
   logic        misaligned;
   logic        mem_wvalid;
   logic        mem_wready;
   logic [31:0] mem_waddr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        ld_valid;
   logic [31:0] ld_addr;
   logic        ld_hazard;
   logic        sb_empty;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
   } model_entry_t;

   model_entry_t sb_model[$];
   bit           storage_clear;

   always #5 clk = ~clk;

   store_unit #(.DEPTH(DEPTH)) dut (
      .clk_i              (clk),
      .rst_i              (rst),
      .st_valid_i         (st_valid),
      .st_ready_o         (st_ready),
      .st_addr_i          (st_addr),
      .st_wdata_i         (st_wdata),
      .store_size_onehot  (st_size),
      .misaligned_store_o (misaligned),
      .mem_wvalid_o       (mem_wvalid),
      .mem_wready_i       (mem_wready),
      .mem_waddr_o        (mem_waddr),
      .mem_wdata_o        (mem_wdata),
      .mem_wstrb_o        (mem_wstrb),
      .ld_valid_i         (ld_valid),
      .ld_addr_i          (ld_addr),
      .ld_hazard_o        (ld_hazard),
      .sb_empty_o         (sb_empty)
   );

   // Size in bytes from the one-hot field, then each covered byte lane k
   // receives source byte (k - offset).
   function automatic void model_format(input logic [31:0] addr, input logic [31:0] wdata,
                                        input logic [2:0] size, output bit size_ok,
                                        output bit mis, output model_entry_t e);
      int nbytes;
      int off;
      nbytes  = size[0] ? 1 : size[1] ? 2 : size[2] ? 4 : 0;
      off     = int'(addr[1:0]);
      size_ok = (nbytes != 0);
      mis     = 1'b0;
      e.addr  = addr & 32'hFFFF_FFFC;
      e.data  = 32'h0;
      e.strb  = 4'h0;
      if (size_ok) begin
         mis = (off % nbytes) != 0;
         for (int k = off; k < off + nbytes && k < 4; k++) begin
            e.strb[k]       = 1'b1;
            e.data[8*k +: 8] = wdata[8*(k-off) +: 8];
         end
      end
   endfunction

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic sv, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [2:0] size, input logic wready,
                                input logic lv, input logic [31:0] laddr);
      st_valid   = sv;
      st_addr    = addr;
      st_wdata   = wdata;
      st_size    = size;
      mem_wready = wready;
      ld_valid   = lv;
      ld_addr    = laddr;
   endtask

   task automatic checkOutput();
      bit           size_ok;
      bit           mis;
      bit           haz;
      model_entry_t e;
      model_format(st_addr, st_wdata, st_size, size_ok, mis, e);
      check("misaligned", {31'b0, misaligned}, {31'b0, st_valid && size_ok && mis});
      haz = 1'b0;
      foreach (sb_model[i]) begin
         if (sb_model[i].addr[31:2] == ld_addr[31:2]) haz = 1'b1;
      end
      check("ld_hazard", {31'b0, ld_hazard}, {31'b0, haz && ld_valid});
      check("st_ready", {31'b0, st_ready}, {31'b0, sb_model.size() < DEPTH});
      check("sb_empty", {31'b0, sb_empty}, {31'b0, sb_model.size() == 0});
      check("mem_wvalid", {31'b0, mem_wvalid}, {31'b0, sb_model.size() != 0});
      if (sb_model.size() != 0) begin
         check("head_waddr", mem_waddr, sb_model[0].addr);
         check("head_wdata", mem_wdata, sb_model[0].data);
         check("head_wstrb", {28'b0, mem_wstrb}, {28'b0, sb_model[0].strb});
      end else if (storage_clear) begin
         check("clr_waddr", mem_waddr, 32'h0);
         check("clr_wdata", mem_wdata, 32'h0);
         check("clr_wstrb", {28'b0, mem_wstrb}, 32'h0);
      end
   endtask

   // Called right at the active edge with the inputs that were sampled.
   task automatic updateModel();
      bit           size_ok;
      bit           mis;
      bit           do_pop;
      bit           do_push;
      model_entry_t e;
      if (rst) begin
         sb_model.delete();
         storage_clear = 1'b1;
      end else begin
         model_format(st_addr, st_wdata, st_size, size_ok, mis, e);
         do_pop  = (sb_model.size() != 0) && mem_wready;
         do_push = st_valid && size_ok && !mis && (sb_model.size() < DEPTH);
         if (do_pop) void'(sb_model.pop_front());
         if (do_push) begin
            sb_model.push_back(e);
            storage_clear = 1'b0;
         end
      end
   endtask

   task automatic runCycle();
      @(negedge clk);
      checkOutput();
      @(posedge clk);
      updateModel();
      #1;
   endtask

   initial begin
      logic [31:0] pool_addr;
      rst = 1'b1;
      applyStimulus(0, 32'h0, 32'h0, 3'b000, 0, 0, 32'h0);
      storage_clear = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      $display("[TB] reset released");

      // Reset state
      check("rst_ready", {31'b0, st_ready}, 32'h1);
      check("rst_empty", {31'b0, sb_empty}, 32'h1);
      check("rst_wvalid", {31'b0, mem_wvalid}, 32'h0);
      runCycle();

      // Byte store at offset 3, drained immediately
      applyStimulus(1, 32'h1003, 32'h0000_00AB, 3'b001, 1, 0, 32'h0);
      runCycle();
      applyStimulus(0, 32'h0, 32'h0, 3'b000, 1, 0, 32'h0);
      check("sb_waddr", mem_waddr, 32'h1000);
      check("sb_wstrb", {28'b0, mem_wstrb}, 32'h8);
      check("sb_wdata", mem_wdata, 32'hAB00_0000);
      runCycle();
      runCycle();

      // Misaligned half from an empty buffer, then an aligned upper half
      applyStimulus(1, 32'h2001, 32'h1234_CAFE, 3'b010, 0, 0, 32'h0);
      #1;
      check("sh_mis", {31'b0, misaligned}, 32'h1);
      runCycle();
      check("sh_mis_empty", {31'b0, sb_empty}, 32'h1);
      applyStimulus(1, 32'h2002, 32'h1234_CAFE, 3'b010, 0, 0, 32'h0);
      runCycle();
      applyStimulus(0, 32'h0, 32'h0, 3'b000, 1, 0, 32'h0);
      check("sh_wstrb", {28'b0, mem_wstrb}, 32'hC);
      check("sh_wdata", mem_wdata, 32'hCAFE_0000);
      runCycle();

      // Three back-to-back words into a two-entry buffer
      applyStimulus(1, 32'h4000, $urandom, 3'b100, 0, 0, 32'h0);
      runCycle();
      applyStimulus(1, 32'h4004, $urandom, 3'b100, 0, 0, 32'h0);
      runCycle();
      applyStimulus(1, 32'h4008, $urandom, 3'b100, 0, 0, 32'h0);
      check("sw_full_ready", {31'b0, st_ready}, 32'h0);
      runCycle();
      mem_wready = 1'b1;
      repeat (2) runCycle();
      st_valid = 1'b0;
      repeat (3) runCycle();

      // Load hazard against a buffered word
      applyStimulus(1, 32'h3000, $urandom, 3'b100, 0, 0, 32'h0);
      runCycle();
      applyStimulus(0, 32'h0, 32'h0, 3'b000, 0, 1, 32'h3002);
      #1;
      check("haz_hit", {31'b0, ld_hazard}, 32'h1);
      runCycle();
      ld_addr = 32'h3004;
      #1;
      check("haz_miss", {31'b0, ld_hazard}, 32'h0);
      runCycle();
      mem_wready = 1'b1;
      runCycle();
      ld_addr = 32'h3002;
      #1;
      check("haz_drained", {31'b0, ld_hazard}, 32'h0);
      runCycle();

      // Reset with a full buffer
      applyStimulus(1, 32'h7000, $urandom, 3'b100, 0, 0, 32'h0);
      runCycle();
      st_addr = 32'h7004;
      runCycle();
      rst = 1'b1;
      mem_wready = 1'b1;
      runCycle();
      rst = 1'b0;
      st_valid = 1'b0;
      check("rstmid_wvalid", {31'b0, mem_wvalid}, 32'h0);
      check("rstmid_empty", {31'b0, sb_empty}, 32'h1);
      check("rstmid_ready", {31'b0, st_ready}, 32'h1);
      repeat (3) runCycle();

      // No size bit set, then two size bits set (byte wins)
      applyStimulus(1, 32'h5001, 32'hFFFF_FFFF, 3'b000, 0, 0, 32'h0);
      #1;
      check("nosize_mis", {31'b0, misaligned}, 32'h0);
      runCycle();
      check("nosize_empty", {31'b0, sb_empty}, 32'h1);
      applyStimulus(1, 32'h5003, 32'h0000_5A5A, 3'b011, 0, 0, 32'h0);
      #1;
      check("multi_mis", {31'b0, misaligned}, 32'h0);
      runCycle();
      st_valid = 1'b0;
      check("multi_wstrb", {28'b0, mem_wstrb}, 32'h8);
      check("multi_wdata", mem_wdata, 32'h5A00_0000);
      mem_wready = 1'b1;
      runCycle();

      // Random traffic over a small address pool to provoke hazards
      for (int n = 0; n < 400; n++) begin
         pool_addr = 32'h6000 + ($urandom_range(0, 3) * 4) + $urandom_range(0, 3);
         applyStimulus($urandom_range(0, 3) != 0, pool_addr, $urandom, 3'($urandom),
                       $urandom_range(0, 2) != 0, 1'($urandom),
                       32'h6000 + ($urandom_range(0, 4) * 4) + $urandom_range(0, 3));
         rst = ($urandom_range(0, 63) == 0);
         runCycle();
      end
      rst = 1'b0;
      applyStimulus(0, 32'h0, 32'h0, 3'b000, 1, 0, 32'h0);
      repeat (4) runCycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
